// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase scheduler.
// Contents: FSM state encoding, quadrant codes (top two accumulator bits) and
// default widths used by the scheduler and its phase accumulator.
package dds_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } dds_state_e;

  // Quadrant codes: acc[ACC_W-1:ACC_W-2]
  localparam logic [1:0] Quad0 = 2'd0;  // rising, positive
  localparam logic [1:0] Quad1 = 2'd1;  // falling, positive
  localparam logic [1:0] Quad2 = 2'd2;  // rising (mirrored), negative
  localparam logic [1:0] Quad3 = 2'd3;  // falling (mirrored), negative

  localparam int unsigned DefaultAccW  = 16;
  localparam int unsigned DefaultAddrW = 6;
  localparam int unsigned DefaultCntW  = 8;

endpackage

// File: rtl/dds_phase_scheduler_phase_accumulator.sv
// Phase accumulator: ACC_W-bit register updated with acc + ftw when enabled.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset (acc -> 0)
//   en    - accumulate this cycle
//   clr   - synchronous clear, wins over en
//   ftw   - frequency tuning word added every enabled cycle
//   acc   - current phase
//   carry - the enabled add overflows this cycle (phase wraps at the next edge)
module phase_accumulator
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W = DefaultAccW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] ftw,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum;

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, ftw};
    carry = en & sum[ACC_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/dds_phase_scheduler.sv
// DDS phase scheduler for a quarter-wave sine datapath.
// Owns the phase accumulator, start/stop/burst control and glitch-free retuning
// (a new tuning word only takes effect when the phase wraps to zero).
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   start         - begin generation (IDLE only)
//   stop          - finish the current period, then return to IDLE
//   ftw_in        - tuning word; ftw_load latches it into the shadow register
//   burst_len     - periods per burst, 0 = continuous (captured on start)
//   addr          - quarter-wave LUT address (raw accumulator bits)
//   phase_pos     - 1 on rising-slope quadrants (0 and 2)
//   sign_bit      - 1 on negative quadrants (2 and 3)
//   sample_valid  - addr/phase_pos/sign_bit carry a live sample
//   cycle_done    - one-cycle pulse after each accumulator wrap
//   ftw_ack       - one-cycle pulse when a loaded word becomes active
//   busy          - not IDLE
module dds_phase_scheduler
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W  = DefaultAccW,
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_load,
  input  logic [CNT_W-1:0]  burst_len,
  output logic [ADDR_W-1:0] addr,
  output logic              phase_pos,
  output logic              sign_bit,
  output logic              sample_valid,
  output logic              cycle_done,
  output logic              ftw_ack,
  output logic              busy
);

  dds_state_e state_q, state_d;

  logic [ACC_W-1:0] ftw_active_q, ftw_active_d;
  logic [ACC_W-1:0] ftw_shadow_q, ftw_shadow_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             cycle_done_q, cycle_done_d;
  logic             ftw_ack_q, ftw_ack_d;

  logic [ACC_W-1:0] acc;
  logic             acc_en;
  logic             acc_clr;
  logic             wrap;
  logic [CNT_W-1:0] count_inc;
  logic             burst_end;
  logic [1:0]       quad;

  assign acc_en    = (state_q != StIdle);
  assign acc_clr   = (state_d == StIdle);
  assign count_inc = count_q + CNT_W'(1);
  assign burst_end = wrap && (burst_q != '0) && (count_inc == burst_q);

  phase_accumulator #(
    .ACC_W (ACC_W)
  ) u_phase_accumulator (
    .clk   (clk),
    .rst   (rst),
    .en    (acc_en),
    .clr   (acc_clr),
    .ftw   (ftw_active_q),
    .acc   (acc),
    .carry (wrap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StRun;
      end
      StRun: begin
        if (burst_end) begin
          state_d = StIdle;
        end else if (stop) begin
          state_d = StStopping;
        end
      end
      StStopping: begin
        // A zero tuning word would never wrap, so leave without waiting.
        if (wrap || (ftw_active_q == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Tuning-word, burst counter and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_active_q <= '0;
      ftw_shadow_q <= '0;
      pending_q    <= 1'b0;
      count_q      <= '0;
      burst_q      <= '0;
      cycle_done_q <= 1'b0;
      ftw_ack_q    <= 1'b0;
    end else begin
      ftw_active_q <= ftw_active_d;
      ftw_shadow_q <= ftw_shadow_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      burst_q      <= burst_d;
      cycle_done_q <= cycle_done_d;
      ftw_ack_q    <= ftw_ack_d;
    end
  end

  always_comb begin
    ftw_active_d = ftw_active_q;
    ftw_shadow_d = ftw_shadow_q;
    pending_d    = pending_q;
    count_d      = count_q;
    burst_d      = burst_q;
    cycle_done_d = 1'b0;
    ftw_ack_d    = 1'b0;

    if (state_q == StIdle) begin
      // No phase to protect while idle: retune immediately.
      if (ftw_load) begin
        ftw_shadow_d = ftw_in;
        ftw_active_d = ftw_in;
        ftw_ack_d    = 1'b1;
      end
      if (start && !stop) begin
        burst_d = burst_len;
        count_d = '0;
      end
    end else begin
      if (wrap) begin
        cycle_done_d = 1'b1;
        count_d      = count_inc;
        if (pending_q) begin
          ftw_active_d = ftw_shadow_q;
          pending_d    = 1'b0;
          ftw_ack_d    = 1'b1;
        end
      end
      // Evaluated after the wrap so a load coinciding with a wrap stays
      // pending for the following wrap.
      if (ftw_load) begin
        ftw_shadow_d = ftw_in;
        pending_d    = 1'b1;
      end
    end
  end

  // Output decode (registers only)
  assign quad = acc[ACC_W-1:ACC_W-2];

  always_comb begin
    sample_valid = (state_q != StIdle);
    busy         = (state_q != StIdle);
    addr         = sample_valid ? acc[ACC_W-3 -: ADDR_W] : '0;
    phase_pos    = sample_valid && ((quad == Quad0) || (quad == Quad2));
    sign_bit     = sample_valid && ((quad == Quad2) || (quad == Quad3));
    cycle_done   = cycle_done_q;
    ftw_ack      = ftw_ack_q;
  end

endmodule
